// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO; define FIFO_SYNC_FWFT_EN for first-word fall-through reads
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] buf_out,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc;
  assign buf_empty    = cnt_q == '0;
  assign buf_full     = cnt_q == (ADDR_W+1)'(DEPTH);
  assign almost_full  = cnt_q >= (ADDR_W+1)'(AF_LVL);
  assign almost_empty = cnt_q <= (ADDR_W+1)'(AE_LVL);
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  // a full FIFO still takes a push when the same edge frees a slot
  assign wr_acc = wr_en & (~buf_full | rd_en);
  assign rd_acc = rd_en & ~buf_empty;
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    cnt_d    = (wr_acc & ~rd_acc) ? cnt_q + (ADDR_W+1)'(1) :
               (rd_acc & ~wr_acc) ? cnt_q - (ADDR_W+1)'(1) : cnt_q;
    ovf_d    = (ovf_q & ~err_clr) | (wr_en & buf_full & ~rd_en);
    udf_d    = (udf_q & ~err_clr) | (rd_en & buf_empty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= buf_in;
  end
`ifdef FIFO_SYNC_FWFT_EN
  assign buf_out = mem[rd_ptr_q];
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  always_comb dout_d = rd_acc ? mem[rd_ptr_q] : dout_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end
  assign buf_out = dout_q;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of fifo_sync_param at default parameters
module tb_fifo_sync_param;
  logic       clk, rst_n, wr_en, rd_en, err_clr;
  logic [7:0] buf_in, buf_out;
  logic       buf_empty, buf_full, almost_full, almost_empty, overflow, underflow;
  logic [3:0] fifo_cnt;
  int n_chk = 0, n_pass = 0;

  fifo_sync_param dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
    .err_clr(err_clr), .buf_out(buf_out), .buf_empty(buf_empty), .buf_full(buf_full),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_cnt(fifo_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    @(negedge clk);
    wr_en = w; rd_en = r; buf_in = d; err_clr = c;
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; err_clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; wr_en = 0; rd_en = 0; err_clr = 0; buf_in = 0;
    #12;
    chk("rst_empty", buf_empty, 1);
    chk("rst_full", buf_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
`ifndef FIFO_SYNC_FWFT_EN
    chk("rst_out", buf_out, 0);
`endif
    @(negedge clk); rst_n = 1;
`ifdef FIFO_SYNC_FWFT_EN
    cyc(1, 0, 8'd42, 0);
    chk("fwft_out", buf_out, 42);
    chk("fwft_nempty", buf_empty, 0);
    @(negedge clk);
    chk("fwft_hold", buf_out, 42);
    cyc(0, 1, 0, 0);
    chk("fwft_cnt", fifo_cnt, 0);
    chk("fwft_empty", buf_empty, 1);
`else
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 8'(i * 10), 0);
      chk("fill_cnt", fifo_cnt, i);
      chk("fill_af", almost_full, i >= 6);
      chk("fill_full", buf_full, i == 8);
    end
    cyc(1, 0, 8'd90, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", fifo_cnt, 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 0);
      chk("drain_out", buf_out, i * 10);
      chk("drain_cnt", fifo_cnt, 8 - i);
      chk("drain_ae", almost_empty, (8 - i) <= 2);
      chk("drain_empty", buf_empty, i == 8);
    end
    chk("ovf_sticky", overflow, 1);
    cyc(0, 1, 0, 0);
    chk("udf_set", underflow, 1);
    chk("udf_out", buf_out, 80);
    cyc(0, 1, 0, 1);
    chk("clr_setwins_udf", underflow, 1);
    chk("clr_ovf", overflow, 0);
    cyc(0, 0, 0, 1);
    chk("clr_udf", underflow, 0);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i), 0);
    chk("b_full", buf_full, 1);
    cyc(1, 1, 8'd99, 0);
    chk("b_out", buf_out, 1);
    chk("b_cnt", fifo_cnt, 8);
    chk("b_ovf", overflow, 0);
    for (int i = 2; i <= 8; i++) begin
      cyc(0, 1, 0, 0);
      chk("wrap_out", buf_out, i);
    end
    cyc(0, 1, 0, 0);
    chk("wrap_last", buf_out, 99);
    chk("wrap_empty", buf_empty, 1);
    cyc(1, 1, 8'd5, 0);
    chk("e_udf", underflow, 1);
    chk("e_cnt", fifo_cnt, 1);
    chk("e_out", buf_out, 99);
    cyc(0, 1, 0, 0);
    chk("e_pop", buf_out, 5);
    chk("e_cnt0", fifo_cnt, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(7 + i), 0);
    cyc(0, 1, 0, 0);
    chk("pre_rst_out", buf_out, 7);
    chk("pre_rst_cnt", fifo_cnt, 2);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("async_cnt", fifo_cnt, 0);
    chk("async_empty", buf_empty, 1);
    chk("async_out", buf_out, 0);
    chk("async_udf", underflow, 0);
    chk("async_ae", almost_empty, 1);
    @(negedge clk); rst_n = 1;
    cyc(1, 0, 8'd33, 0);
    cyc(0, 1, 0, 0);
    chk("post_rst_out", buf_out, 33);
    chk("post_rst_cnt", fifo_cnt, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
